// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Holds the read-owner tag, the default widths and the grant bit positions.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int STARVE_MAX_DEF = 3;

    localparam int GNT_IF = 0;
    localparam int GNT_D  = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_prio.sv
// Data-priority winner selection with a saturating fetch-starvation counter.
// Grant is combinational from the requests; no backpressure, loser simply retries.
module arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       if_req_i,
    input  logic       d_req_i,
    output logic [1:0] gnt_o
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          starved;

    assign starved = (starve_q == SW'(STARVE_MAX));

    always_comb begin
        gnt_o = '0;
        if (rst_n_i) begin
            if (if_req_i && (!d_req_i || starved)) begin
                gnt_o[GNT_IF] = 1'b1;
            end else if (d_req_i) begin
                gnt_o[GNT_D] = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || gnt_o[GNT_IF]) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between fetch and data ports; read data returns one cycle after grant.
// Requesters hold their request until gnt; the idle address is held from a registered copy.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [15:0]       conflict_cnt
);

    logic [1:0]        gnt;
    owner_e            owner_q;
    owner_e            owner_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       conflict_q;
    logic [15:0]       conflict_d;

    arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk_i    (clock),
        .rst_n_i  (reset),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .gnt_o    (gnt)
    );

    assign if_gnt = gnt[GNT_IF];
    assign d_gnt  = gnt[GNT_D];

    always_comb begin
        mem_addr = addr_q;
        if (d_gnt) begin
            mem_addr = d_addr;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    assign mem_din = d_wdata;
    assign mem_we  = d_gnt & d_we;

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_D;
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (if_req && d_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_q    <= OWN_NONE;
            addr_q     <= '0;
            conflict_q <= '0;
        end else begin
            owner_q    <= owner_d;
            addr_q     <= mem_addr;
            conflict_q <= conflict_d;
        end
    end

    // Gated by reset so an in-flight read never surfaces while reset is held.
    assign if_rvalid    = reset && (owner_q == OWN_IF);
    assign d_rvalid     = reset && (owner_q == OWN_D);
    assign if_rdata     = mem_dout;
    assign d_rdata      = mem_dout;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous-read memory model behind it.
// Inputs change on the falling edge; all outputs are sampled 1ns later.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic [15:0] mem_dout;
    logic [15:0] conflict_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:255];

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .STARVE_MAX (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_we       (mem_we),
        .mem_dout     (mem_dout),
        .conflict_cnt (conflict_cnt)
    );

    // Write-first synchronous memory.
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[7:0]] = mem_din;
        mem_dout <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    initial begin
        bit exp_d;
        bit prev_d;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        mem[0] = 16'h0008;
        mem[1] = 16'h1111;
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 16'h0000;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0003;
        d_wdata = 16'h1234;

        // Reset held two cycles with both requests high.
        for (int c = 0; c < 2; c++) begin
            next_cycle(); #1;
            chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
            chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
            chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        end
        chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);

        next_cycle();
        reset  = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        #1;
        chk("idle_conflict", {16'd0, conflict_cnt}, 32'd0);

        // Fetch-only read of address 0.
        next_cycle();
        if_req = 1'b1; if_addr = 16'h0000;
        #1;
        chk("fetch_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("fetch_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("fetch_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("fetch_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        if_req = 1'b0;
        #1;
        chk("fetch_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fetch_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("fetch_if_rdata", {16'd0, if_rdata}, 32'h0008);

        // Data write then read-back of address 5.
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0005; d_wdata = 16'hBEEF;
        #1;
        chk("wr_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("wr_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_addr", {16'd0, mem_addr}, 32'h0005);
        chk("wr_mem_din", {16'd0, mem_din}, 32'hBEEF);
        next_cycle();
        d_we = 1'b0;
        #1;
        chk("rd_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rd_no_rvalid_after_wr", {31'd0, d_rvalid}, 32'd0);
        next_cycle();
        d_req = 1'b0;
        #1;
        chk("rd_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("rd_d_rdata", {16'd0, d_rdata}, 32'hBEEF);
        chk("idle_mem_addr_hold", {16'd0, mem_addr}, 32'h0005);
        chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
        chk("idle_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);

        // Continuous contention: D, D, D, IF repeating.
        prev_d = 1'b0;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            if_req = 1'b1; if_addr = 16'h0001;
            d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
            #1;
            exp_d = ((k % 4) != 3);
            chk("starve_d_gnt", {31'd0, d_gnt}, {31'd0, exp_d});
            chk("starve_if_gnt", {31'd0, if_gnt}, {31'd0, !exp_d});
            chk("starve_conflict", {16'd0, conflict_cnt}, 32'(k));
            if (k > 0) begin
                chk("starve_d_rvalid", {31'd0, d_rvalid}, {31'd0, prev_d});
                chk("starve_rdata", {16'd0, d_rdata}, prev_d ? 32'h0002 : 32'h1111);
            end
            prev_d = exp_d;
        end

        // Fetch read granted, then reset pulled low while it is in flight.
        next_cycle();
        d_req = 1'b0;
        #1;
        chk("flight_conflict", {16'd0, conflict_cnt}, 32'd8);
        chk("flight_if_gnt", {31'd0, if_gnt}, 32'd1);
        next_cycle();
        reset = 1'b0; if_req = 1'b0;
        #1;
        chk("flight_no_rvalid_in_rst", {31'd0, if_rvalid}, 32'd0);
        next_cycle();
        reset = 1'b1;
        #1;
        chk("flight_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("flight_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("flight_owner", {30'd0, dut.owner_q}, {30'd0, OWN_NONE});
        chk("flight_conflict_clr", {16'd0, conflict_cnt}, 32'd0);
        chk("flight_starve_clr", 32'(dut.u_arb.starve_q), 32'd0);

        // Saturation of the conflict counter.
        next_cycle();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        force dut.conflict_q = 16'hFFFE;
        #1;
        release dut.conflict_q;
        chk("sat_preload", {16'd0, conflict_cnt}, 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            chk("sat_hold", {16'd0, conflict_cnt}, 32'hFFFF);
        end

        next_cycle();
        if_req = 1'b0; d_req = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
